// File: rtl/bnn_accum_act_if.sv
// Stream bundle between the MAC array, the accumulate/activate stage and the ofmap buffer.
// The slave view is the accumulate/activate block; the master view is its environment.
interface bnn_accum_act_if #(
  parameter int PSUM_WIDTH = 5,
  parameter int ACC_WIDTH  = 12
);
  logic [PSUM_WIDTH-1:0] psum_in;
  logic                  psum_valid;
  logic                  psum_ready;
  logic [ACC_WIDTH-1:0]  out_data;
  logic                  out_valid;
  logic                  out_last;
  logic                  out_ready;

  modport master (
    output psum_in, psum_valid, out_ready,
    input  psum_ready, out_data, out_valid, out_last
  );

  modport slave (
    input  psum_in, psum_valid, out_ready,
    output psum_ready, out_data, out_valid, out_last
  );
endinterface

// File: rtl/bnn_accum_act.sv
// Accumulates MAC popcounts across input channels into one pixel, then emits either the raw
// saturated sum or a thresholded sign bit packed LSB-first into output words.
module bnn_accum_act #(
  parameter int PSUM_WIDTH = 5,
  parameter int ACC_WIDTH  = 12,
  parameter int PACK_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_start,
  input  logic [7:0]           i_ch_count,
  input  logic [15:0]          i_pix_count,
  input  logic [ACC_WIDTH-1:0] i_threshold,
  input  logic                 i_raw_mode,
  bnn_accum_act_if.slave       io,
  output logic                 o_busy,
  output logic                 o_done
);

  localparam int BIT_W = (PACK_WIDTH > 1) ? $clog2(PACK_WIDTH) : 1;
  localparam int SUM_W = ACC_WIDTH + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t                r_state;
  logic [7:0]            r_ch_max;
  logic [7:0]            r_ch_idx;
  logic [15:0]           r_pix_max;
  logic [15:0]           r_pix_idx;
  logic [ACC_WIDTH-1:0]  r_threshold;
  logic                  r_raw_mode;
  logic [ACC_WIDTH-1:0]  r_acc;
  logic [PACK_WIDTH-1:0] r_pack;
  logic [BIT_W-1:0]      r_bit_idx;
  logic [ACC_WIDTH-1:0]  r_out_data;
  logic                  r_out_valid;
  logic                  r_out_last;
  logic                  r_done;

  logic                  w_psum_ready;
  logic                  w_psum_fire;
  logic                  w_out_fire;
  logic [SUM_W-1:0]      w_sum_wide;
  logic [ACC_WIDTH-1:0]  w_sum;
  logic                  w_ch_done;
  logic                  w_pix_last;
  logic                  w_bit;
  logic                  w_word_full;
  logic [PACK_WIDTH-1:0] w_pack_next;

  // Ready depends only on registers, so out_ready never reaches psum_ready combinationally.
  assign w_psum_ready = (r_state == S_RUN) && !r_out_valid;
  assign w_psum_fire  = io.psum_valid && w_psum_ready;
  assign w_out_fire   = r_out_valid && io.out_ready;

  assign w_sum_wide  = {1'b0, r_acc} + SUM_W'(io.psum_in);
  assign w_sum       = w_sum_wide[ACC_WIDTH] ? '1 : w_sum_wide[ACC_WIDTH-1:0];
  assign w_ch_done   = (r_ch_idx == r_ch_max);
  assign w_pix_last  = (r_pix_idx == r_pix_max);
  assign w_bit       = (w_sum >= r_threshold);
  assign w_word_full = (r_bit_idx == BIT_W'(PACK_WIDTH - 1));
  assign w_pack_next = r_pack | (PACK_WIDTH'(w_bit) << r_bit_idx);

  // NOTE: every register below is written with <= so all updates use pre-edge values,
  // which keeps the sum/pack/emit decisions of one beat mutually consistent.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_ch_max    <= '0;
      r_ch_idx    <= '0;
      r_pix_max   <= '0;
      r_pix_idx   <= '0;
      r_threshold <= '0;
      r_raw_mode  <= 1'b0;
      r_acc       <= '0;
      r_pack      <= '0;
      r_bit_idx   <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_out_fire) begin
        r_out_valid <= 1'b0;
        r_out_last  <= 1'b0;
      end

      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_ch_max    <= (i_ch_count == 8'd0) ? 8'd0 : i_ch_count - 8'd1;
            r_pix_max   <= i_pix_count - 16'd1;
            r_threshold <= i_threshold;
            r_raw_mode  <= i_raw_mode;
            r_ch_idx    <= '0;
            r_pix_idx   <= '0;
            r_acc       <= '0;
            r_pack      <= '0;
            r_bit_idx   <= '0;
            if (i_pix_count == 16'd0) r_done  <= 1'b1;
            else                      r_state <= S_RUN;
          end
        end

        S_RUN: begin
          if (w_psum_fire) begin
            if (!w_ch_done) begin
              r_acc    <= w_sum;
              r_ch_idx <= r_ch_idx + 8'd1;
            end else begin
              r_acc     <= '0;
              r_ch_idx  <= '0;
              r_pix_idx <= r_pix_idx + 16'd1;
              if (r_raw_mode) begin
                r_out_data  <= w_sum;
                r_out_valid <= 1'b1;
                r_out_last  <= w_pix_last;
              end else if (w_word_full || w_pix_last) begin
                r_out_data  <= ACC_WIDTH'(w_pack_next);
                r_out_valid <= 1'b1;
                r_out_last  <= w_pix_last;
                r_pack      <= '0;
                r_bit_idx   <= '0;
              end else begin
                r_pack    <= w_pack_next;
                r_bit_idx <= r_bit_idx + BIT_W'(1);
              end
              if (w_pix_last) r_state <= S_DRAIN;
            end
          end
        end

        S_DRAIN: begin
          if (w_out_fire) begin
            r_state <= S_IDLE;
            r_done  <= 1'b1;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign io.psum_ready = w_psum_ready;
  assign io.out_data   = r_out_data;
  assign io.out_valid  = r_out_valid;
  assign io.out_last   = r_out_last;
  assign o_busy        = (r_state != S_IDLE);
  assign o_done        = r_done;

endmodule

// File: tb/tb_bnn_accum_act.sv
// Directed bench for bnn_accum_act: packing, backpressure, partial words, raw mode,
// saturation, ch_count=0, reset mid-job and start handling, with hand-computed expectations.
module tb_bnn_accum_act;

  localparam int PW = 5;
  localparam int AW = 12;
  localparam int KW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start;
  logic [7:0]    ch_count;
  logic [15:0]   pix_count;
  logic [AW-1:0] threshold;
  logic          raw_mode;
  logic          busy;
  logic          done;

  int n_cmp    = 0;
  int n_err    = 0;
  int done_cnt = 0;

  logic [AW-1:0] q_data[$];
  logic          q_last[$];

  always #5 clk = ~clk;

  bnn_accum_act_if #(.PSUM_WIDTH(PW), .ACC_WIDTH(AW)) bus ();

  bnn_accum_act #(.PSUM_WIDTH(PW), .ACC_WIDTH(AW), .PACK_WIDTH(KW)) dut (
    .clk         (clk),
    .rst         (rst),
    .i_start     (start),
    .i_ch_count  (ch_count),
    .i_pix_count (pix_count),
    .i_threshold (threshold),
    .i_raw_mode  (raw_mode),
    .io          (bus.slave),
    .o_busy      (busy),
    .o_done      (done)
  );

  // Inputs change at posedge+1, so a negedge sample sees exactly what the next edge will use.
  always @(negedge clk) begin
    if (bus.out_valid && bus.out_ready) begin
      q_data.push_back(bus.out_data);
      q_last.push_back(bus.out_last);
    end
    if (done) done_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_words();
    q_data.delete();
    q_last.delete();
  endtask

  task automatic check_word(input string tag, input int idx, input logic [AW-1:0] exp_data,
                            input logic exp_last);
    check({tag, "_present"}, 32'(q_data.size() > idx), 32'd1);
    if (q_data.size() > idx) begin
      check({tag, "_data"}, 32'(q_data[idx]), 32'(exp_data));
      check({tag, "_last"}, 32'(q_last[idx]), 32'(exp_last));
    end
  endtask

  task automatic start_job(input logic [7:0] ch, input logic [15:0] pix, input logic [AW-1:0] thr,
                           input logic raw);
    ch_count  = ch;
    pix_count = pix;
    threshold = thr;
    raw_mode  = raw;
    start     = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send(input logic [PW-1:0] v);
    bit got = 1'b0;
    int n   = 0;
    bus.psum_in    = v;
    bus.psum_valid = 1'b1;
    while (!got && n < 100) begin
      @(negedge clk);
      got = bus.psum_ready;
      @(posedge clk); #1;
      n++;
    end
    bus.psum_valid = 1'b0;
    if (!got) check("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_done(input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge clk);
      seen = done;
    end
    check({tag, "_done"}, 32'(seen), 32'd1);
    @(negedge clk);
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
    check({tag, "_idle"}, 32'(busy), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    // NOTE: the bench drives DUT inputs with blocking assignments away from the clock edge.
    start          = 1'b0;
    ch_count       = '0;
    pix_count      = '0;
    threshold      = '0;
    raw_mode       = 1'b0;
    bus.psum_in    = '0;
    bus.psum_valid = 1'b0;
    bus.out_ready  = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_psum_ready", 32'(bus.psum_ready), 32'd0);
    check("rst_out_valid",  32'(bus.out_valid),  32'd0);
    check("rst_out_last",   32'(bus.out_last),   32'd0);
    check("rst_out_data",   32'(bus.out_data),   32'd0);
    check("rst_busy",       32'(busy),           32'd0);
    check("rst_done",       32'(done),           32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Binary packing: even pixels sum 6 (bit 1), odd pixels sum 5 (bit 0) -> 0x55.
    clear_words();
    start_job(8'd3, 16'd8, 12'd6, 1'b0);
    @(negedge clk);
    check("t1_busy", 32'(busy), 32'd1);
    @(posedge clk); #1;
    for (int p = 0; p < 8; p++) begin
      send((p % 2) ? 5'd1 : 5'd2);
      send(5'd2);
      send(5'd2);
    end
    wait_done("t1");
    check("t1_words", 32'(q_data.size()), 32'd1);
    check_word("t1_w0", 0, 12'h055, 1'b1);

    // Backpressure on the first of two words.
    clear_words();
    bus.out_ready = 1'b0;
    start_job(8'd3, 16'd16, 12'd6, 1'b0);
    fork
      begin
        for (int p = 0; p < 16; p++) begin
          send((p % 2) ? 5'd1 : 5'd2);
          send(5'd2);
          send(5'd2);
        end
      end
      begin
        bit seen_v = 1'b0;
        for (int i = 0; i < 200 && !seen_v; i++) begin
          @(negedge clk);
          seen_v = bus.out_valid;
        end
        check("t2_first_valid", 32'(seen_v), 32'd1);
        for (int k = 0; k < 5; k++) begin
          if (k > 0) @(negedge clk);
          check("t2_stall_ready", 32'(bus.psum_ready), 32'd0);
          check("t2_stall_valid", 32'(bus.out_valid),  32'd1);
          check("t2_stall_data",  32'(bus.out_data),   32'h55);
        end
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
      end
    join
    wait_done("t2");
    check("t2_words", 32'(q_data.size()), 32'd2);
    check_word("t2_w0", 0, 12'h055, 1'b0);
    check_word("t2_w1", 1, 12'h055, 1'b1);

    // Partial word: three pixels, threshold 0 -> 0x07.
    clear_words();
    start_job(8'd1, 16'd3, 12'd0, 1'b0);
    send(5'd5);
    send(5'd0);
    send(5'd9);
    wait_done("t3");
    check("t3_words", 32'(q_data.size()), 32'd1);
    check_word("t3_w0", 0, 12'h007, 1'b1);

    // Raw mode: 4+3=7, 31+31=62.
    clear_words();
    start_job(8'd2, 16'd2, 12'd0, 1'b1);
    send(5'd4);
    send(5'd3);
    send(5'd31);
    send(5'd31);
    wait_done("t4");
    check("t4_words", 32'(q_data.size()), 32'd2);
    check_word("t4_w0", 0, 12'd7,  1'b0);
    check_word("t4_w1", 1, 12'd62, 1'b1);

    // Saturation: 255 * 31 = 7905 clamps to 4095.
    clear_words();
    start_job(8'd255, 16'd1, 12'd0, 1'b1);
    repeat (255) send(5'd31);
    wait_done("t5a");
    check("t5a_words", 32'(q_data.size()), 32'd1);
    check_word("t5a_w0", 0, 12'd4095, 1'b1);

    // ch_count = 0 behaves as one channel per pixel.
    clear_words();
    start_job(8'd0, 16'd3, 12'd0, 1'b1);
    send(5'd10);
    send(5'd20);
    send(5'd30);
    wait_done("t5b");
    check("t5b_words", 32'(q_data.size()), 32'd3);
    check_word("t5b_w0", 0, 12'd10, 1'b0);
    check_word("t5b_w1", 1, 12'd20, 1'b0);
    check_word("t5b_w2", 2, 12'd30, 1'b1);

    // Reset mid-pixel, then a fresh job must not see the stale accumulator (62).
    clear_words();
    start_job(8'd3, 16'd1, 12'd0, 1'b1);
    send(5'd31);
    send(5'd31);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("t6a_psum_ready", 32'(bus.psum_ready), 32'd0);
    check("t6a_out_valid",  32'(bus.out_valid),  32'd0);
    check("t6a_out_last",   32'(bus.out_last),   32'd0);
    check("t6a_out_data",   32'(bus.out_data),   32'd0);
    check("t6a_busy",       32'(busy),           32'd0);
    check("t6a_done",       32'(done),           32'd0);
    @(posedge clk); #1;
    start_job(8'd2, 16'd1, 12'd0, 1'b1);
    send(5'd1);
    send(5'd2);
    wait_done("t6a");
    check("t6a_words", 32'(q_data.size()), 32'd1);
    check_word("t6a_w0", 0, 12'd3, 1'b1);

    // start during RUN is ignored: job stays 2 channels x 2 pixels raw.
    clear_words();
    start_job(8'd2, 16'd2, 12'd0, 1'b1);
    send(5'd5);
    start_job(8'd1, 16'd1, 12'd0, 1'b0);
    @(negedge clk);
    check("t6b_busy", 32'(busy), 32'd1);
    @(posedge clk); #1;
    send(5'd6);
    send(5'd1);
    send(5'd1);
    wait_done("t6b");
    check("t6b_words", 32'(q_data.size()), 32'd2);
    check_word("t6b_w0", 0, 12'd11, 1'b0);
    check_word("t6b_w1", 1, 12'd2,  1'b1);

    // pix_count = 0: done the next cycle, never busy, nothing emitted.
    clear_words();
    begin
      int dc0;
      dc0 = done_cnt;
      start_job(8'd4, 16'd0, 12'd0, 1'b1);
      @(negedge clk);
      check("t6c_done", 32'(done), 32'd1);
      check("t6c_busy", 32'(busy), 32'd0);
      repeat (5) @(negedge clk);
      check("t6c_words",      32'(q_data.size()),  32'd0);
      check("t6c_done_count", 32'(done_cnt - dc0), 32'd1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
